// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: FSM encoding and wait-counter limits.
package pipe_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REPLAY   = 2'd2
  } flow_state_e;

  localparam int unsigned  CNT_W           = 8;
  localparam logic [7:0]   CNT_MAX         = 8'd255;
  localparam logic [7:0]   TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/pipe_flow_ctrl_wait_cnt.sv
// Data-memory wait counter: saturating count of stalled cycles plus a sticky timeout flag.
import pipe_flow_ctrl_pkg::*;

module flow_wait_cnt #(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_one,
  input  logic inc,
  input  logic clr,
  input  logic in_wait,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load_one) begin
      cnt_reg <= 8'd1;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // Sticky until reset; the FSM keeps waiting, the flag only reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (in_wait && (cnt_reg == TIMEOUT)) begin
      timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Five-stage pipeline hazard controller: memory waits, RF write-port replay, branch redirect, load-use.
import pipe_flow_ctrl_pkg::*;

module pipe_flow_ctrl #(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_load_use_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        mem_req_i,
  input  logic        dmem_ack_i,
  input  logic        rf_port_busy_i,
  output logic        fc_stall_pc_o,
  output logic        fc_stall_ifid_o,
  output logic        fc_stall_idex_o,
  output logic        fc_stall_exmem_o,
  output logic        fc_flush_ifid_o,
  output logic        fc_flush_idex_o,
  output logic        fc_flush_exmem_o,
  output logic        fc_flush_memwb_o,
  output logic        fc_bk_memwb_o,
  output logic        fc_wb_kill_o,
  output logic        fc_pc_we_o,
  output logic [31:0] fc_pc_o,
  output logic        fc_mem_timeout_o
);

  flow_state_e state_reg, state_next;
  logic        wait_now;
  logic        cnt_load_one, cnt_inc, cnt_clr, cnt_in_wait;

  assign wait_now = mem_req_i && !dmem_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (rf_port_busy_i)  state_next = ST_REPLAY;
        else if (wait_now)   state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: if (dmem_ack_i) state_next = ST_RUN;
      ST_REPLAY:   state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  // Priority: replay entry > memory wait > branch > load-use; all zero while in reset.
  always_comb begin
    fc_stall_pc_o    = 1'b0;
    fc_stall_ifid_o  = 1'b0;
    fc_stall_idex_o  = 1'b0;
    fc_stall_exmem_o = 1'b0;
    fc_flush_ifid_o  = 1'b0;
    fc_flush_idex_o  = 1'b0;
    fc_flush_exmem_o = 1'b0;
    fc_flush_memwb_o = 1'b0;
    fc_bk_memwb_o    = 1'b0;
    fc_wb_kill_o     = 1'b0;
    fc_pc_we_o       = 1'b0;
    fc_pc_o          = 32'd0;
    cnt_load_one     = 1'b0;
    cnt_inc          = 1'b0;
    cnt_clr          = 1'b0;
    cnt_in_wait      = 1'b0;
    if (rst_n) begin
      case (state_reg)
        ST_RUN: begin
          if (rf_port_busy_i) begin
            {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o} = 4'b1111;
          end else if (wait_now) begin
            {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o} = 4'b1111;
            fc_flush_memwb_o = 1'b1;
            cnt_load_one     = 1'b1;
          end else if (ex_branch_taken_i) begin
            fc_pc_we_o      = 1'b1;
            fc_pc_o         = ex_target_i;
            fc_flush_ifid_o = 1'b1;
            fc_flush_idex_o = 1'b1;
          end else if (id_load_use_i) begin
            fc_stall_pc_o   = 1'b1;
            fc_stall_ifid_o = 1'b1;
            fc_flush_idex_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          cnt_in_wait = 1'b1;
          if (dmem_ack_i) begin
            cnt_clr = 1'b1;
          end else begin
            {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o} = 4'b1111;
            fc_flush_memwb_o = 1'b1;
            cnt_inc          = 1'b1;
          end
        end
        ST_REPLAY: begin
          {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o} = 4'b1111;
          fc_bk_memwb_o = 1'b1;
          fc_wb_kill_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  flow_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (cnt_load_one),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .in_wait  (cnt_in_wait),
    .timeout  (fc_mem_timeout_o)
  );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed self-checking bench for pipe_flow_ctrl (TIMEOUT=4 instance).
module tb_pipe_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_load_use_i, ex_branch_taken_i, mem_req_i, dmem_ack_i, rf_port_busy_i;
  logic [31:0] ex_target_i;
  logic        fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o;
  logic        fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o;
  logic        fc_bk_memwb_o, fc_wb_kill_o, fc_pc_we_o, fc_mem_timeout_o;
  logic [31:0] fc_pc_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  // {stall pc,ifid,idex,exmem, flush ifid,idex,exmem,memwb, bk, kill, pc_we}
  localparam logic [10:0] C_NONE    = 11'b0000_0000_000;
  localparam logic [10:0] C_STALL4  = 11'b1111_0000_000;
  localparam logic [10:0] C_MEMWAIT = 11'b1111_0001_000;
  localparam logic [10:0] C_BRANCH  = 11'b0000_1100_001;
  localparam logic [10:0] C_LOADUSE = 11'b1100_0100_000;
  localparam logic [10:0] C_REPLAY  = 11'b1111_0000_110;

  logic [10:0] ctl;
  assign ctl = {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o,
                fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o,
                fc_bk_memwb_o, fc_wb_kill_o, fc_pc_we_o};

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_load_use_i     (id_load_use_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_target_i       (ex_target_i),
    .mem_req_i         (mem_req_i),
    .dmem_ack_i        (dmem_ack_i),
    .rf_port_busy_i    (rf_port_busy_i),
    .fc_stall_pc_o     (fc_stall_pc_o),
    .fc_stall_ifid_o   (fc_stall_ifid_o),
    .fc_stall_idex_o   (fc_stall_idex_o),
    .fc_stall_exmem_o  (fc_stall_exmem_o),
    .fc_flush_ifid_o   (fc_flush_ifid_o),
    .fc_flush_idex_o   (fc_flush_idex_o),
    .fc_flush_exmem_o  (fc_flush_exmem_o),
    .fc_flush_memwb_o  (fc_flush_memwb_o),
    .fc_bk_memwb_o     (fc_bk_memwb_o),
    .fc_wb_kill_o      (fc_wb_kill_o),
    .fc_pc_we_o        (fc_pc_we_o),
    .fc_pc_o           (fc_pc_o),
    .fc_mem_timeout_o  (fc_mem_timeout_o)
  );

  // Apply one cycle's inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic lu, input logic br, input logic [31:0] tgt,
                       input logic mr, input logic ack, input logic busy);
    @(negedge clk);
    id_load_use_i     = lu;
    ex_branch_taken_i = br;
    ex_target_i       = tgt;
    mem_req_i         = mr;
    dmem_ack_i        = ack;
    rf_port_busy_i    = busy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_load_use_i = 1'b1; ex_branch_taken_i = 1'b1; ex_target_i = 32'hDEAD_BEEF;
    mem_req_i = 1'b1; dmem_ack_i = 1'b0; rf_port_busy_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if (fc_pc_o !== 32'd0 || fc_mem_timeout_o !== 1'b0)
      $display("FAIL reset_pc_to: got pc=%h to=%b expected pc=0 to=0", fc_pc_o, fc_mem_timeout_o);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_LOADUSE) $display("FAIL load_use: got %b expected %b", ctl, C_LOADUSE);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL load_use_release: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    $display("load-use one cycle done");
  endtask

  task automatic test_branch();
    drive(1, 1, 32'h0000_1040, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_BRANCH || fc_pc_o !== 32'h0000_1040)
      $display("FAIL branch: got ctl=%b pc=%h expected ctl=%b pc=00001040", ctl, fc_pc_o, C_BRANCH);
    else pass_cnt++;
    drive(0, 0, 32'h0000_2000, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_NONE || fc_pc_o !== 32'd0)
      $display("FAIL branch_idle_pc: got ctl=%b pc=%h expected ctl=%b pc=0", ctl, fc_pc_o, C_NONE);
    else pass_cnt++;
    $display("branch to 0x1040 done");
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 0, 1, 0, 0);
    total_cnt++;
    if (ctl !== C_MEMWAIT) $display("FAIL mem_wait_enter: got %b expected %b", ctl, C_MEMWAIT);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h0000_3000, 1, 0, 1);
      total_cnt++;
      if (ctl !== C_MEMWAIT || fc_pc_o !== 32'd0)
        $display("FAIL mem_wait_hold%0d: got ctl=%b pc=%h expected ctl=%b pc=0", i, ctl, fc_pc_o, C_MEMWAIT);
      else pass_cnt++;
    end
    drive(0, 0, 0, 1, 1, 0);
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL mem_ack: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    drive(1, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_LOADUSE) $display("FAIL mem_back_to_run: got %b expected %b", ctl, C_LOADUSE);
    else pass_cnt++;
    drive(0, 0, 0, 1, 1, 0);
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL zero_wait: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    $display("memory wait of 3 cycles done");
  endtask

  task automatic test_replay();
    drive(1, 1, 32'h0000_4000, 1, 0, 1);
    total_cnt++;
    if (ctl !== C_STALL4) $display("FAIL busy_stall: got %b expected %b", ctl, C_STALL4);
    else pass_cnt++;
    drive(0, 1, 32'h0000_4000, 0, 0, 1);
    total_cnt++;
    if (ctl !== C_REPLAY) $display("FAIL replay: got %b expected %b", ctl, C_REPLAY);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL replay_exit: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    $display("rf port replay done");
  endtask

  task automatic test_timeout();
    drive(0, 0, 0, 1, 0, 0);
    // counter reads 1..4 in wait cycles 1..4; the flag shows from wait cycle 5
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      total_cnt++;
      if (fc_mem_timeout_o !== (k >= 5) || ctl !== C_MEMWAIT)
        $display("FAIL timeout_cycle%0d: got to=%b ctl=%b expected to=%b ctl=%b",
                 k, fc_mem_timeout_o, ctl, (k >= 5), C_MEMWAIT);
      else pass_cnt++;
    end
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (fc_mem_timeout_o !== 1'b1 || ctl !== C_NONE)
      $display("FAIL timeout_sticky: got to=%b ctl=%b expected to=1 ctl=%b", fc_mem_timeout_o, ctl, C_NONE);
    else pass_cnt++;
    $display("timeout with TIMEOUT=4 done");
  endtask

  task automatic test_reset_mid_op();
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== C_NONE || fc_mem_timeout_o !== 1'b0)
      $display("FAIL reset_mid_wait: got ctl=%b to=%b expected ctl=%b to=0", ctl, fc_mem_timeout_o, C_NONE);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_NONE) $display("FAIL after_reset_wait: got %b expected %b", ctl, C_NONE);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    total_cnt++;
    if (ctl !== C_LOADUSE) $display("FAIL after_reset_replay: got %b expected %b", ctl, C_LOADUSE);
    else pass_cnt++;
    $display("reset mid-operation done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_replay();
    test_timeout();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
